// File: rtl/neuron_setup_sequencer.sv
// rtl/neuron_setup_sequencer.sv - framed byte-stream sequencer that programs and runs the LIF/PWM neuron pair
//
// Purpose:
//   Decodes a header byte (opcode in bits [7:5]) followed by a payload.
//   Config opcodes become one-cycle setup strobes carrying setup_control/setup_data.
//   The RUN opcode enables the neuron for a programmed number of cycles while counting spikes.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   in_data/in_valid    command/payload byte stream from the host
//   in_ready            byte accepted when in_valid & in_ready
//   abort               synchronous return to IDLE
//   spike_in            neuron spike output sampled while execute is high
//   setup_control/data  register select and byte for the neuron config registers
//   setup_strobe        one-cycle write enable
//   execute             neuron enable during RUN
//   busy                high outside IDLE
//   done                one-cycle pulse at the end of a run
//   spike_count         saturating spike count of the last/current run
//   error               sticky, set by the reserved opcode
module neuron_setup_sequencer #(
  parameter int CFG_BYTES      = 4,
  parameter int SPIKE_CNT_BITS = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [7:0]                in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      abort,
  input  logic                      spike_in,
  output logic [2:0]                setup_control,
  output logic [7:0]                setup_data,
  output logic                      setup_strobe,
  output logic                      execute,
  output logic                      busy,
  output logic                      done,
  output logic [SPIKE_CNT_BITS-1:0] spike_count,
  output logic                      error
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RUNCNT = 3'd2,
    S_RUN    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [2:0] OP_RESERVED = 3'b101;
  localparam logic [2:0] OP_RUN      = 3'b111;

  // Multi-byte payload length, never less than one byte.
  localparam logic [7:0] CFG_LEN = (CFG_BYTES < 1) ? 8'd1 : 8'(CFG_BYTES);

  state_t                    state_q;
  logic [2:0]                opcode_q;
  logic [7:0]                rem_q;
  logic [7:0]                run_left_q;
  logic [2:0]                setup_control_q;
  logic [7:0]                setup_data_q;
  logic                      setup_strobe_q;
  logic                      execute_q;
  logic                      done_q;
  logic [SPIKE_CNT_BITS-1:0] spike_count_q;
  logic                      error_q;

  logic [7:0]                payload_len_d;
  logic [SPIKE_CNT_BITS-1:0] spike_count_d;
  logic                      ready_state;
  logic                      accept;

  // Abort also drops in_ready so a byte presented in the abort cycle is not silently lost.
  assign ready_state = (state_q == S_IDLE) || (state_q == S_LOAD) || (state_q == S_RUNCNT);
  assign in_ready    = ready_state && !abort;
  assign accept      = in_valid && in_ready;

  always_comb begin
    payload_len_d = 8'd1;
    if (in_data[7:6] == 2'b00) begin
      payload_len_d = CFG_LEN;
    end
  end

  assign spike_count_d = (&spike_count_q) ? spike_count_q
                                          : spike_count_q + SPIKE_CNT_BITS'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      opcode_q        <= 3'd0;
      rem_q           <= 8'd0;
      run_left_q      <= 8'd0;
      setup_control_q <= 3'd0;
      setup_data_q    <= 8'd0;
      setup_strobe_q  <= 1'b0;
      execute_q       <= 1'b0;
      done_q          <= 1'b0;
      spike_count_q   <= '0;
      error_q         <= 1'b0;
    end else begin
      // Strobe and done are single-cycle pulses unless re-armed below.
      setup_strobe_q <= 1'b0;
      done_q         <= 1'b0;

      if (abort) begin
        state_q    <= S_IDLE;
        execute_q  <= 1'b0;
        rem_q      <= 8'd0;
        run_left_q <= 8'd0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (accept) begin
              opcode_q <= in_data[7:5];
              rem_q    <= payload_len_d;
              if (in_data[7:5] == OP_RESERVED) begin
                error_q <= 1'b1;
              end else if (in_data[7:5] == OP_RUN) begin
                state_q <= S_RUNCNT;
              end else begin
                state_q <= S_LOAD;
              end
            end
          end

          S_LOAD: begin
            if (accept) begin
              setup_data_q    <= in_data;
              setup_control_q <= opcode_q;
              setup_strobe_q  <= 1'b1;
              rem_q           <= rem_q - 8'd1;
              if (rem_q == 8'd1) begin
                state_q <= S_IDLE;
              end
            end
          end

          S_RUNCNT: begin
            if (accept) begin
              spike_count_q <= '0;
              run_left_q    <= in_data;
              if (in_data == 8'd0) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q   <= S_RUN;
                execute_q <= 1'b1;
              end
            end
          end

          S_RUN: begin
            if (execute_q && spike_in) begin
              spike_count_q <= spike_count_d;
            end
            run_left_q <= run_left_q - 8'd1;
            // run_left_q counts the execute cycles still to go, including this one.
            if (run_left_q <= 8'd1) begin
              execute_q <= 1'b0;
              state_q   <= S_DONE;
              done_q    <= 1'b1;
            end
          end

          S_DONE: begin
            state_q <= S_IDLE;
          end

          default: begin
            state_q   <= S_IDLE;
            execute_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign setup_control = setup_control_q;
  assign setup_data    = setup_data_q;
  assign setup_strobe  = setup_strobe_q;
  assign execute       = execute_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign spike_count   = spike_count_q;
  assign error         = error_q;

endmodule
